rt_icache_sa: RTL and testbench

Parametrised set-associative instruction cache controller for the RT-Core, the successor to the 2KB direct-mapped RT I-cache. It sits between the RT-Core fetch port and the ROM controller in the 50MHz RT domain. It adds configurable ways, sets and line size, and per-way locking for deterministic hot loops. It also adds an uncached bypass mode and recoverable ROM-timeout errors with an error return instead of a stuck state.

---
 rtl/rt_icache_sa.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_rt_icache_sa.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_icache_sa.sv
// Set-associative RT-Core instruction cache with way locking,
// uncached bypass and recoverable ROM-timeout error returns.
module rt_icache_sa #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WORDS       = 8,
    parameter int SETS        = 128,
    parameter int WAYS        = 2,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic              clk_rt_50mhz,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              cpu_err,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_ready,
    input  logic              cache_enable,
    input  logic              cache_flush,
    input  logic [WAYS-1:0]   lock_mask,
    output logic              cache_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       err_count
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);
    localparam logic [7:0]       STALL_MAX = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        BYPASS,
        RESP,
        ERR,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;

    assign req_tag = req_addr[ADDR_W-1:IDX_W+OFF_W];
    assign req_idx = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_off = req_addr[OFF_W-1:0];

    logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid    [WAYS];
    logic [WAY_W-1:0]  rr_ptr   [SETS];

    logic [WAY_W-1:0]  victim;
    logic [OFF_W-1:0]  fill_cnt;
    logic [7:0]        stall_cnt;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;
    logic              flush_pending;
    logic [IDX_W-1:0]  flush_idx;

    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic              rr_found;
    logic [WAY_W-1:0]  rr_way;
    logic [WAY_W-1:0]  cand;
    logic              victim_ok;
    logic [WAY_W-1:0]  victim_sel;
    logic              fill_last;
    logic              stall_out;

    // Parallel tag compare plus victim choice for the captured set.
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        rr_found  = 1'b0;
        rr_way    = '0;
        cand      = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid[w][req_idx] &&
                tag_mem[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid[w][req_idx] && !lock_mask[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            cand = rr_ptr[req_idx] + WAY_W'(k);
            if (!rr_found && !lock_mask[cand]) begin
                rr_found = 1'b1;
                rr_way   = cand;
            end
        end
        victim_ok  = inv_found || rr_found;
        victim_sel = inv_found ? inv_way : rr_way;
    end

    assign fill_last = rom_ready && (fill_cnt == LAST_WORD);
    assign stall_out = !rom_ready && (stall_cnt == STALL_MAX);

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (flush_pending) begin
                    state_nx = FLUSH;
                end else if (cpu_req) begin
                    state_nx = cache_enable ? LOOKUP : BYPASS;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    state_nx = RESP;
                end else if (victim_ok) begin
                    state_nx = FILL;
                end else begin
                    state_nx = BYPASS;
                end
            end
            FILL: begin
                if (fill_last) begin
                    state_nx = RESP;
                end else if (stall_out) begin
                    state_nx = ERR;
                end
            end
            BYPASS: begin
                if (rom_ready) begin
                    state_nx = RESP;
                end else if (stall_out) begin
                    state_nx = ERR;
                end
            end
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            FLUSH: begin
                if (flush_idx == LAST_SET) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_ready   = (state == RESP) || (state == ERR);
    assign cpu_err     = (state == ERR);
    assign cpu_hit     = (state == RESP) && resp_hit;
    assign cpu_data    = (state == RESP) ? resp_data : '0;
    assign rom_req     = (state == FILL) || (state == BYPASS);
    assign cache_ready = (state == IDLE) && !flush_pending;

    always_comb begin
        rom_addr = '0;
        if (state == FILL) begin
            rom_addr = {req_addr[ADDR_W-1:OFF_W], fill_cnt};
        end else if (state == BYPASS) begin
            rom_addr = req_addr;
        end
    end

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            req_addr      <= '0;
            victim        <= '0;
            fill_cnt      <= '0;
            stall_cnt     <= '0;
            resp_data     <= '0;
            resp_hit      <= 1'b0;
            flush_pending <= 1'b0;
            flush_idx     <= '0;
        end else begin
            // A new flush request outranks consumption of the old one.
            if (cache_flush) begin
                flush_pending <= 1'b1;
            end else if (state == IDLE && flush_pending) begin
                flush_pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    flush_idx <= '0;
                    stall_cnt <= '0;
                    resp_hit  <= 1'b0;
                    if (!flush_pending && cpu_req) begin
                        req_addr <= cpu_addr;
                    end
                end
                LOOKUP: begin
                    resp_hit  <= hit_any;
                    resp_data <= data_mem[hit_way][req_idx][req_off];
                    victim    <= victim_sel;
                    fill_cnt  <= '0;
                    stall_cnt <= '0;
                end
                FILL: begin
                    if (rom_ready) begin
                        fill_cnt  <= fill_cnt + 1'b1;
                        stall_cnt <= '0;
                        if (fill_cnt == req_off) begin
                            resp_data <= rom_data;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                BYPASS: begin
                    if (rom_ready) begin
                        resp_data <= rom_data;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    flush_idx <= flush_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            if (state == LOOKUP && !hit_any && victim_ok) begin
                valid[victim_sel][req_idx] <= 1'b0;
                rr_ptr[req_idx] <= (victim_sel == LAST_WAY) ?
                                   '0 : victim_sel + 1'b1;
            end
            if (state == FILL && fill_last) begin
                valid[victim][req_idx] <= 1'b1;
            end
            if (state == FLUSH) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[w][flush_idx] <= 1'b0;
                end
                rr_ptr[flush_idx] <= '0;
            end
        end
    end

    // Line storage has no reset; validity alone qualifies its contents.
    always_ff @(posedge clk_rt_50mhz) begin
        if (state == FILL && rom_ready) begin
            data_mem[victim][req_idx][fill_cnt] <= rom_data;
        end
        if (state == FILL && fill_last) begin
            tag_mem[victim][req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            err_count  <= '0;
        end else begin
            if (state == LOOKUP && hit_any && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (state == LOOKUP && !hit_any && miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
            if (state == ERR && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rt_icache_sa.sv
// Self-checking bench for rt_icache_sa: directed scenarios followed by
// random fetches, all checked against a rule-level cache model.
module tb_rt_icache_sa;

    localparam int WORDS   = 8;
    localparam int SETS    = 128;
    localparam int WAYS    = 2;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        cpu_hit;
    logic        cpu_err;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_ready;
    logic        cache_enable;
    logic        cache_flush;
    logic [1:0]  lock_mask;
    logic        cache_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] err_count;

    logic rom_req_d;
    logic rom_dead;

    int errors = 0;
    int checks = 0;

    bit m_valid [WAYS][SETS];
    int m_tag   [WAYS][SETS];
    int m_ptr   [SETS];
    int m_hits;
    int m_misses;
    int m_errs;

    always #10 clk = ~clk;

    rt_icache_sa dut (
        .clk_rt_50mhz (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_ready    (cpu_ready),
        .cpu_hit      (cpu_hit),
        .cpu_err      (cpu_err),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_ready    (rom_ready),
        .cache_enable (cache_enable),
        .cache_flush  (cache_flush),
        .lock_mask    (lock_mask),
        .cache_ready  (cache_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .err_count    (err_count)
    );

    // ROM answers one cycle after a request opens, then one word per cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rom_req_d <= 1'b0;
        else        rom_req_d <= rom_req;
    end
    assign rom_ready = rom_req && rom_req_d && !rom_dead;
    assign rom_data  = rom_addr ^ 16'hA5A5;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    endtask

    function automatic int pick_victim(input int s);
        int v;
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_valid[w][s] && !lock_mask[w]) v = w;
        for (int k = 0; k < WAYS; k++)
            if (v < 0 && !lock_mask[(m_ptr[s] + k) % WAYS])
                v = (m_ptr[s] + k) % WAYS;
        return v;
    endfunction

    task automatic access(input int addr, input bit drop_req,
                          input int flush_at);
        int s, t, v, mode, n, cyc, first, nready, badaddr;
        int exp_first, exp_lat, exp_ready;
        bit exp_hit, exp_err, got, r_hit, r_err;
        logic [15:0] exp_data, r_data, want;
        s = (addr >> 3) % SETS;
        t = addr >> 10;
        exp_hit  = 1'b0;
        exp_err  = 1'b0;
        exp_data = 16'(addr) ^ 16'hA5A5;
        exp_first = -1;
        v = -1;
        if (!cache_enable) begin
            mode = 2;
            exp_first = 1;
        end else begin
            for (int w = 0; w < WAYS; w++)
                if (m_valid[w][s] && m_tag[w][s] == t) v = w;
            if (v >= 0) begin
                mode = 0;
                exp_hit = 1'b1;
                m_hits++;
            end else begin
                m_misses++;
                exp_first = 2;
                v = pick_victim(s);
                if (v < 0) begin
                    mode = 2;
                end else begin
                    mode = 1;
                    m_valid[v][s] = 1'b0;
                    m_ptr[s] = (v + 1) % WAYS;
                end
            end
        end
        if (mode == 0) begin
            exp_lat = 2;
            exp_ready = 0;
        end else if (rom_dead) begin
            exp_err = 1'b1;
            exp_lat = exp_first + TIMEOUT;
            exp_ready = 0;
            exp_data = 16'h0000;
            m_errs++;
        end else if (mode == 1) begin
            exp_lat = exp_first + 1 + WORDS;
            exp_ready = WORDS;
            m_valid[v][s] = 1'b1;
            m_tag[v][s] = t;
        end else begin
            exp_lat = exp_first + 2;
            exp_ready = 1;
        end

        n = 0;
        while (!cache_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", 32'(cache_ready), 32'(1));
        cpu_addr = 16'(addr);
        cpu_req = 1'b1;
        cyc = 0;
        first = -1;
        nready = 0;
        badaddr = 0;
        got = 1'b0;
        r_data = '0;
        r_hit = 1'b0;
        r_err = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (drop_req) cpu_req = 1'b0;
            cache_flush = (cyc == flush_at);
            if (rom_req && first < 0) first = cyc;
            if (rom_ready) begin
                want = (mode == 1) ? ((16'(addr) & 16'hFFF8) + 16'(nready))
                                   : 16'(addr);
                if (rom_addr !== want) badaddr++;
                nready++;
            end
            if (cpu_ready) begin
                got = 1'b1;
                r_data = cpu_data;
                r_hit = cpu_hit;
                r_err = cpu_err;
                cpu_req = 1'b0;
            end
        end
        cache_flush = 1'b0;
        cpu_req = 1'b0;
        check("ready_seen", 32'(got), 32'(1));
        check("latency", 32'(cyc), 32'(exp_lat));
        check("data", 32'(r_data), 32'(exp_data));
        check("hit", 32'(r_hit), 32'(exp_hit));
        check("err", 32'(r_err), 32'(exp_err));
        check("first_rom_req", 32'(first), 32'(exp_first));
        check("rom_words", 32'(nready), 32'(exp_ready));
        check("rom_addr_seq", 32'(badaddr), 32'(0));
        @(posedge clk); #1;
        check("ready_pulse", 32'(cpu_ready), 32'(0));
        check("rom_req_off", 32'(rom_req), 32'(0));
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
        check("err_count", err_count, 32'(m_errs));
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        cpu_addr = '0;
        cache_enable = 1'b1;
        cache_flush = 1'b0;
        lock_mask = 2'b00;
        rom_dead = 1'b0;
        m_hits = 0;
        m_misses = 0;
        m_errs = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'(0));
        check("rst_cpu_data", 32'(cpu_data), 32'(0));
        check("rst_cpu_hit", 32'(cpu_hit), 32'(0));
        check("rst_cpu_err", 32'(cpu_err), 32'(0));
        check("rst_rom_req", 32'(rom_req), 32'(0));
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_cache_ready", 32'(cache_ready), 32'(1));
        check("rst_hits", hit_count, 32'(0));
        check("rst_misses", miss_count, 32'(0));
        check("rst_errs", err_count, 32'(0));
        @(posedge clk); #1;

        access(16'h0123, 1'b0, -1);
        access(16'h0125, 1'b0, -1);

        access(16'h0000, 1'b0, -1);
        access(16'h0400, 1'b0, -1);
        access(16'h0800, 1'b0, -1);
        access(16'h0400, 1'b0, -1);
        access(16'h0000, 1'b0, -1);

        // Flush raised mid-fill with the request already dropped.
        access(16'h1000, 1'b1, 5);
        n = 0;
        while (!cache_ready && n < 400) begin
            n++;
            @(posedge clk); #1;
        end
        check("flush_len_min", 32'(n >= SETS), 32'(1));
        check("flush_len_max", 32'(n <= SETS + 1), 32'(1));
        model_clear();
        access(16'h0125, 1'b0, -1);

        access(16'h0000, 1'b0, -1);
        lock_mask = 2'b01;
        access(16'h0400, 1'b0, -1);
        access(16'h0800, 1'b0, -1);
        access(16'h0000, 1'b0, -1);
        access(16'h0400, 1'b0, -1);
        access(16'h0800, 1'b0, -1);
        access(16'h0000, 1'b0, -1);
        lock_mask = 2'b11;
        access(16'h0C00, 1'b0, -1);
        access(16'h0C00, 1'b0, -1);
        lock_mask = 2'b00;

        rom_dead = 1'b1;
        access(16'h2000, 1'b0, -1);
        rom_dead = 1'b0;
        access(16'h2000, 1'b0, -1);
        access(16'h2003, 1'b0, -1);

        cache_enable = 1'b0;
        access(16'h0010, 1'b0, -1);
        cache_enable = 1'b1;
        access(16'h0010, 1'b0, -1);

        // Reset in the middle of a fill must leave the line invalid.
        cpu_addr = 16'h3008;
        cpu_req = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rom_req", 32'(rom_req), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midrst_hits", hit_count, 32'(0));
        check("midrst_misses", miss_count, 32'(0));
        check("midrst_ready", 32'(cache_ready), 32'(1));
        m_hits = 0;
        m_misses = 0;
        m_errs = 0;
        model_clear();
        @(posedge clk); #1;
        access(16'h3008, 1'b0, -1);

        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 19) begin
                cache_flush = 1'b1;
                @(posedge clk); #1;
                cache_flush = 1'b0;
                model_clear();
            end
            a = (($urandom % 4) << 10) | (($urandom % 4) << 3) |
                ($urandom % 8);
            cache_enable = (($urandom % 8) != 0);
            lock_mask = (($urandom % 4) == 0) ? 2'($urandom % 4) : 2'b00;
            access(a, 1'($urandom % 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
